// File: rtl/m_dm_ctrl.sv
// m_dm_ctrl: MEM-stage data-memory controller.
// Byte/half/word stores with read-modify-write lane merge and signed/unsigned
// loads, behind a fixed-latency req/ready/resp_valid handshake. Alignment and
// range faults are reported through err. After reset the whole array is
// cleared one word per cycle before the first access is accepted.
module m_dm_ctrl #(
  parameter int          DEPTH     = 3072,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
  localparam logic            LAT_ONE  = (LATENCY == 1) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // ------------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------------

  // Replace the addressed lane(s) of old_word with store data; other lanes kept.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] st_data,
    input logic [1:0]  sz,
    input logic [1:0]  lo
  );
    logic [31:0] w;
    w = old_word;
    case (sz)
      SZ_BYTE: begin
        case (lo)
          2'd0:    w[7:0]   = st_data[7:0];
          2'd1:    w[15:8]  = st_data[7:0];
          2'd2:    w[23:16] = st_data[7:0];
          2'd3:    w[31:24] = st_data[7:0];
          default: w        = old_word;
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) begin
          w[31:16] = st_data[15:0];
        end else begin
          w[15:0]  = st_data[15:0];
        end
      end
      SZ_WORD: w = st_data;
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half of a word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic        zext,
    input logic [1:0]  lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = 32'h0000_0000;
    case (sz)
      SZ_BYTE: begin
        case (lo)
          2'd0:    b = word[7:0];
          2'd1:    b = word[15:8];
          2'd2:    b = word[23:16];
          2'd3:    b = word[31:24];
          default: b = 8'h00;
        endcase
        r = zext ? {24'h00_0000, b} : {{24{b[7]}}, b};
      end
      SZ_HALF: begin
        h = lo[1] ? word[31:16] : word[15:0];
        r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
      end
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Size/alignment fault: illegal size code or a misaligned half/word.
  function automatic logic align_fault(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic f;
    case (sz)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = lo[0];
      SZ_WORD: f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // ------------------------------------------------------------------------
  // Storage and state
  // ------------------------------------------------------------------------
  logic [31:0]      mem_r [0:DEPTH-1];

  logic [1:0]       state_r;
  logic [3:0]       cnt_r;
  logic [IDX_W-1:0] clr_idx_r;

  logic             we_r;
  logic [1:0]       size_r;
  logic             uns_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      pc_r;

  logic             ready_r;
  logic             busy_r;
  logic             resp_valid_r;
  logic [31:0]      rdata_r;
  logic             err_r;

  // ------------------------------------------------------------------------
  // Combinational datapath
  // ------------------------------------------------------------------------
  logic             accept_s;
  logic             commit_s;
  logic             a_we_s;
  logic [1:0]       a_size_s;
  logic             a_uns_s;
  logic [31:0]      a_addr_s;
  logic [31:0]      a_wdata_s;
  logic [31:0]      a_pc_s;
  logic [29:0]      word_off_s;
  logic             range_err_s;
  logic             err_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      old_word_s;
  logic [31:0]      merged_s;
  logic [31:0]      load_s;

  logic [1:0]       state_nx_s;
  logic [3:0]       cnt_nx_s;
  logic [IDX_W-1:0] clr_idx_nx_s;

  // Access fields: with single-cycle latency the commit happens on the accept
  // edge itself, so the live inputs are used while IDLE, latched copies later.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req;
    if (state_r == ST_IDLE) begin
      a_we_s    = we;
      a_size_s  = size;
      a_uns_s   = uns;
      a_addr_s  = addr;
      a_wdata_s = wdata;
      a_pc_s    = pc;
    end else begin
      a_we_s    = we_r;
      a_size_s  = size_r;
      a_uns_s   = uns_r;
      a_addr_s  = addr_r;
      a_wdata_s = wdata_r;
      a_pc_s    = pc_r;
    end
    commit_s = reset && ((accept_s && LAT_ONE) ||
                         ((state_r == ST_WAIT) && (cnt_r == 4'd1)));
  end

  // Address decode, fault classification, lane merge and load extraction.
  always_comb begin
    word_off_s  = a_addr_s[31:2] - BASE_ADDR[31:2];
    range_err_s = (a_addr_s < BASE_ADDR) || (word_off_s >= DEPTH_W);
    err_s       = range_err_s || align_fault(a_size_s, a_addr_s[1:0]);
    // Out-of-range indices are steered to word 0 so the read never leaves
    // the array; the result is discarded by err_s anyway.
    if (range_err_s) begin
      idx_s = {IDX_W{1'b0}};
    end else begin
      idx_s = word_off_s[IDX_W-1:0];
    end
    old_word_s = mem_r[idx_s];
    merged_s   = merge_lanes(old_word_s, a_wdata_s, a_size_s, a_addr_s[1:0]);
    load_s     = extract_load(old_word_s, a_size_s, a_uns_s, a_addr_s[1:0]);
  end

  // Next-state logic for the clear sweep and the access handshake.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    clr_idx_nx_s = clr_idx_r;
    case (state_r)
      ST_INIT: begin
        if (clr_idx_r == LAST_IDX) begin
          state_nx_s   = ST_IDLE;
          clr_idx_nx_s = {IDX_W{1'b0}};
        end else begin
          state_nx_s   = ST_INIT;
          clr_idx_nx_s = clr_idx_r + 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          cnt_nx_s   = CNT_INIT;
          state_nx_s = LAT_ONE ? ST_RESP : ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nx_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s   = ST_INIT;
        clr_idx_nx_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------------

  // Control state, latched request and registered handshake/response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_INIT;
      cnt_r        <= 4'd0;
      clr_idx_r    <= {IDX_W{1'b0}};
      we_r         <= 1'b0;
      size_r       <= 2'd0;
      uns_r        <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      pc_r         <= 32'h0000_0000;
      ready_r      <= 1'b0;
      busy_r       <= 1'b1;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      clr_idx_r    <= clr_idx_nx_s;
      ready_r      <= (state_nx_s == ST_IDLE);
      busy_r       <= (state_nx_s != ST_IDLE);
      resp_valid_r <= (state_nx_s == ST_RESP);
      if (accept_s) begin
        we_r    <= we;
        size_r  <= size;
        uns_r   <= uns;
        addr_r  <= addr;
        wdata_r <= wdata;
        pc_r    <= pc;
      end
      if (commit_s) begin
        err_r   <= err_s;
        rdata_r <= (err_s || a_we_s) ? 32'h0000_0000 : load_s;
      end
    end
  end

  // Memory array: clear sweep while initialising, merged store on commit.
  always_ff @(posedge clk) begin
    if (reset && (state_r == ST_INIT)) begin
      mem_r[clr_idx_r] <= 32'h0000_0000;
    end else if (commit_s && a_we_s && !err_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

`ifndef SYNTHESIS
  // Store trace: one line per committed store showing the merged word.
  always_ff @(posedge clk) begin
    if (commit_s && a_we_s && !err_s) begin
      $display("%d@%h: *%h <= %h", $time, a_pc_s, {a_addr_s[31:2], 2'b00}, merged_s);
    end
  end
`endif

  assign ready      = ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign rdata      = rdata_r;
  assign err        = err_r;

endmodule

// File: tb/tb_m_dm_ctrl.sv
// Directed self-checking bench for m_dm_ctrl. Three instances with
// LATENCY 1, 2 and 3 share one request bus; only the instance under test is
// out of reset at any time, so the others ignore the shared stimulus.
module tb_m_dm_ctrl;

  logic        clk;
  logic [3:1]  rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;

  logic [3:1]  rdy;
  logic [3:1]  bsy;
  logic [3:1]  rv;
  logic [3:1]  er;
  logic [31:0] rd [1:3];

  int n_chk;
  int n_fail;

  m_dm_ctrl #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
    .clk(clk), .reset(rst[1]), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(rdy[1]), .busy(bsy[1]),
    .resp_valid(rv[1]), .rdata(rd[1]), .err(er[1]));

  m_dm_ctrl #(.DEPTH(16), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_l2 (
    .clk(clk), .reset(rst[2]), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(rdy[2]), .busy(bsy[2]),
    .resp_valid(rv[2]), .rdata(rd[2]), .err(er[2]));

  m_dm_ctrl #(.DEPTH(16), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_l3 (
    .clk(clk), .reset(rst[3]), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(rdy[3]), .busy(bsy[3]),
    .resp_valid(rv[3]), .rdata(rd[3]), .err(er[3]));

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count cycles until instance s raises ready (bounded) and check the count.
  task automatic wait_sweep(input int s, input string tag);
    int   n;
    logic seen_rv;
    n = 0;
    seen_rv = 1'b0;
    while (!rdy[s] && n < 100) begin
      @(posedge clk); #1;
      n++;
      seen_rv = seen_rv | rv[s];
    end
    check(tag, 32'(n), 32'd16);
    check({tag, "_no_rv"}, {31'd0, seen_rv}, 32'd0);
    check({tag, "_busy"}, {31'd0, bsy[s]}, 32'd0);
  endtask

  // One request on instance s; checks accept->resp latency, returns response.
  task automatic do_access(input int s, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] wd,
                           input int lat, output logic [31:0] rdo, output logic eo);
    int n;
    n = 0;
    while (!rdy[s] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, rdy[s]}, 32'd1);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd; pc = pc + 32'd4;
    @(posedge clk); #1;
    req = 1'b0;
    n = 1;
    while (!rv[s] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    rdo = rd[s];
    eo  = er[s];
  endtask

  logic [31:0] r;
  logic        e;
  int          n_rv;

  initial begin
    clk = 1'b0; rst = 3'b000; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0000_1000;
    n_chk = 0; n_fail = 0;

    // Reset state of the LATENCY=2 instance after three cycles in reset.
    repeat (3) begin @(posedge clk); #1; end
    check("rst_ready", {31'd0, rdy[2]}, 32'd0);
    check("rst_busy",  {31'd0, bsy[2]}, 32'd1);
    check("rst_rv",    {31'd0, rv[2]},  32'd0);
    check("rst_rdata", rd[2],           32'h0);
    check("rst_err",   {31'd0, er[2]},  32'd0);
    rst[2] = 1'b1;
    wait_sweep(2, "sweep2");

    do_access(2, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 2, r, e);
    check("lw_3c", r, 32'h0);
    check("lw_3c_err", {31'd0, e}, 32'd0);

    // Store, byte merge, read back.
    do_access(2, 1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344, 2, r, e);
    check("sw_8_err", {31'd0, e}, 32'd0);
    do_access(2, 1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AA, 2, r, e);
    check("sb_9_err", {31'd0, e}, 32'd0);
    do_access(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 2, r, e);
    check("lw_8", r, 32'h1122_AA44);

    // Sub-word loads with sign and zero extension.
    do_access(2, 1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 2, r, e);
    check("lb_9", r, 32'hFFFF_FFAA);
    do_access(2, 1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 2, r, e);
    check("lbu_9", r, 32'h0000_00AA);
    do_access(2, 1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 2, r, e);
    check("lh_a", r, 32'h0000_1122);
    do_access(2, 1'b0, 2'd1, 1'b1, 32'h8, 32'h0, 2, r, e);
    check("lhu_8", r, 32'h0000_AA44);

    // Faulting accesses: err=1, rdata=0, memory untouched.
    do_access(2, 1'b1, 2'd1, 1'b0, 32'h5, 32'hBEEF, 2, r, e);
    check("sh_5_err", {31'd0, e}, 32'd1);
    check("sh_5_rd", r, 32'h0);
    do_access(2, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 2, r, e);
    check("lw_6_err", {31'd0, e}, 32'd1);
    check("lw_6_rd", r, 32'h0);
    do_access(2, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 2, r, e);
    check("sw_40_err", {31'd0, e}, 32'd1);
    do_access(2, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 2, r, e);
    check("lw_40_err", {31'd0, e}, 32'd1);
    check("lw_40_rd", r, 32'h0);
    do_access(2, 1'b1, 2'd3, 1'b0, 32'h8, 32'hCAFE_F00D, 2, r, e);
    check("sz3_err", {31'd0, e}, 32'd1);
    do_access(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 2, r, e);
    check("lw_8_keep", r, 32'h1122_AA44);
    check("lw_8_keep_err", {31'd0, e}, 32'd0);
    do_access(2, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 2, r, e);
    check("lw_4_keep", r, 32'h0);

    // LATENCY=3: reset during an in-flight store aborts it.
    @(posedge clk); #1;
    rst[2] = 1'b0; rst[3] = 1'b1;
    wait_sweep(3, "sweep3a");
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    req = 1'b0; rst[3] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_rv", {31'd0, rv[3]}, 32'd0);
      check("abort_ready", {31'd0, rdy[3]}, 32'd0);
    end
    rst[3] = 1'b1;
    wait_sweep(3, "sweep3b");
    do_access(3, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 3, r, e);
    check("l3_lw_0", r, 32'h0);
    check("l3_lw_0_err", {31'd0, e}, 32'd0);

    // LATENCY=1: commit on the accept edge, then back-to-back requests.
    @(posedge clk); #1;
    rst[3] = 1'b0; rst[1] = 1'b1;
    wait_sweep(1, "sweep1");
    do_access(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h1234_5678, 1, r, e);
    check("l1_sw_err", {31'd0, e}, 32'd0);
    do_access(1, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 1, r, e);
    check("l1_lh_6", r, 32'h0000_1234);
    @(posedge clk); #1;
    check("l1_idle_ready", {31'd0, rdy[1]}, 32'd1);
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h4;
    n_rv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("hold_rv", {31'd0, rv[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("hold_ready", {31'd0, rdy[1]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (rv[1]) begin
        n_rv++;
        check("hold_rdata", rd[1], 32'h1234_5678);
      end
    end
    req = 1'b0;
    check("hold_count", 32'(n_rv), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m_dm_ctrl.md
Name: m_dm_ctrl

Overview:
- Parametrised data-memory controller for the MEM stage. Successor to the single-cycle word-only DM.
- Adds byte/half/word stores and signed/unsigned loads.
- Adds a fixed-latency req/ready/resp_valid handshake, alignment and range error reporting, and a sequential memory clear after reset.
- Sits between the M-stage pipeline register and the stall unit. The stall unit holds M while busy=1.

Parameters:
- DEPTH, 3072, number of 32-bit words in the array. Word index = addr[31:2] - BASE_ADDR[31:2].
- LATENCY, 2, cycles from request accept to resp_valid. Legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be word-aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- req  in  1  access request. Sampled only when ready=1.
- we  in  1  1=store, 0=load. Sampled with req.
- size  in  2  access size: 0=byte, 1=half, 2=word. Value 3 is illegal and reported as an error.
- uns  in  1  load extension: 1=zero-extend, 0=sign-extend. Ignored for stores and word loads.
- addr  in  32  byte address.
- wdata  in  32  store data. Low byte or low half is used for sb/sh.
- pc  in  32  PC of the M-stage instruction. Used for the store log only.
- ready  out  1  controller can accept req this cycle.
- busy  out  1  access in flight, or clear sweep running.
- resp_valid  out  1  one-cycle pulse when the access completes.
- rdata  out  32  extended load data. Valid while resp_valid=1.
- err  out  1  access rejected. Valid while resp_valid=1.

Behaviour:
- Reset values: ready=0, busy=1, resp_valid=0, rdata=0, err=0, state=INIT, clr_idx=0.
- States and transitions:
  - INIT: writes MEM[clr_idx]=0 each cycle, clr_idx++. After clr_idx==DEPTH-1 has been written, go to IDLE. The sweep takes exactly DEPTH cycles after reset deasserts. While reset stays low, hold clr_idx=0.
  - IDLE: ready=1, busy=0. On req=1, latch we/size/uns/addr/wdata/pc and load cnt=LATENCY-1. If LATENCY==1 go to RESP, else go to WAIT.
  - WAIT: ready=0, busy=1. Decrement cnt each cycle. When cnt==1, go to RESP.
  - RESP: resp_valid=1, ready=0, busy=1. Go to IDLE next cycle. Throughput is one access per LATENCY+1 cycles.
- Latency: resp_valid is high in the cycle exactly LATENCY edges after the accept edge.
- Commit timing: loads read and stores write on the edge that enters RESP. rdata and err are registered on that same edge. A load accepted on the cycle after RESP sees the new data.
- Error conditions (checked at the commit edge):
  - size==3.
  - size==1 with addr[0]=1.
  - size==2 with addr[1:0]!=0.
  - addr below BASE_ADDR, or word index >= DEPTH.
- On error: err=1, rdata=0, no memory write, no log line.
- Store lane merge: read-modify-write of the target word.
  - sb: byte lane addr[1:0] <= wdata[7:0].
  - sh: half lane addr[1] <= wdata[15:0].
  - sw: full word.
  - All other lanes are preserved.
- Store log: every committed store prints "%d@%h: *%h <= %h" with $time, latched pc, the word-aligned byte address, and the full merged word.
- Load extraction: select the byte or half by addr[1:0], then sign- or zero-extend to 32 bits per uns.
- Reset in any state: aborts the pending access. A latched store is not committed. No resp_valid is produced. The controller returns to INIT, and the sweep restarts from index 0.
- req while ready=0: ignored, not queued. The requester must hold req until it sees ready.

Test Plan:
- DEPTH=16, LATENCY=2, reset low for 3 cycles then released -> ready stays 0 for 16 cycles, then rises. A lw from 0x3C returns 0, err=0, with resp_valid 2 cycles after accept.
- sw 0x11223344 to 0x8, then sb 0xAA to 0x9 -> log shows the merged word 0x1122AA44. lw from 0x8 returns 0x1122AA44.
- Memory word 0x8 = 0x1122AA44 -> lb 0x9 = 0xFFFFFFAA; lbu 0x9 = 0x000000AA; lh 0xA = 0x00001122; lhu 0x8 = 0x0000AA44.
- sh to 0x5; lw to 0x6; any access to 0x40 (index 16); size=3 -> each returns err=1, rdata=0, no log line, memory unchanged.
- LATENCY=3: accept sw at cycle t, pull reset low at t+1 -> no resp_valid, no log line. After the sweep, lw returns 0.
- req held high continuously with LATENCY=1 -> accepts on alternating cycles. resp_valid is high exactly one cycle per access, and ready=0 during RESP.
